// File: rtl/lmsm_uop_if.sv
// Handshake and micro-op bus between register-read, the LM/SM/LA/SA
// sequencer and the execute-stage ALU.
interface lmsm_uop_if #(
  parameter int NREG = 8,
  parameter int AW   = 16
);
  logic          flush;
  logic          in_valid;
  logic [15:0]   in_instr;
  logic [AW-1:0] in_base;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [5:0]    out_instr_exe_6bit;
  logic [2:0]    out_reg;
  logic [AW-1:0] out_addr;
  logic          out_is_store;
  logic          out_last;

  // Upstream/downstream environment drives instructions and back-pressure.
  modport master (
    output flush, in_valid, in_instr, in_base, out_ready,
    input  in_ready, out_valid, out_instr_exe_6bit, out_reg, out_addr,
           out_is_store, out_last
  );

  // The sequencer consumes instructions and produces micro-ops.
  modport slave (
    input  flush, in_valid, in_instr, in_base, out_ready,
    output in_ready, out_valid, out_instr_exe_6bit, out_reg, out_addr,
           out_is_store, out_last
  );
endinterface

// File: rtl/lmsm_uop_sequencer.sv
// Micro-op sequencer between register-read and the ALU. Ordinary
// instructions pass through as one micro-op; LM/SM/LA/SA expand into one
// micro-op per selected register, ascending, at consecutive word addresses.
module lmsm_uop_sequencer #(
  parameter int NREG = 8,
  parameter int AW   = 16
) (
  input logic        clk,
  input logic        rst,
  lmsm_uop_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic [NREG-1:0] rem_p0, rem_n;
  logic            vld_p0, vld_n;
  logic [5:0]      exe6_p0, exe6_n;
  logic [2:0]      reg_p0, reg_n;
  logic [AW-1:0]   addr_p0, addr_n;
  logic            store_p0, store_n;
  logic            last_p0, last_n;

  logic            is_multi;
  logic [NREG-1:0] acc_mask;
  logic [NREG-1:0] acc_rem;
  logic [NREG-1:0] run_rem;
  logic            unused_bits;

  // Index of the lowest set bit; callers guarantee the mask is non-zero.
  function automatic logic [2:0] lowest_idx(input logic [NREG-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Clear the lowest set bit (the register just issued).
  function automatic logic [NREG-1:0] drop_lowest(input logic [NREG-1:0] m);
    return m & (m - NREG'(1));
  endfunction

  assign unused_bits = bus.in_instr[8];

  assign bus.in_ready = bus.out_ready && (state == IDLE) && !bus.flush;

  assign bus.out_valid          = vld_p0;
  assign bus.out_instr_exe_6bit = exe6_p0;
  assign bus.out_reg            = reg_p0;
  assign bus.out_addr           = addr_p0;
  assign bus.out_is_store       = store_p0;
  assign bus.out_last           = last_p0;

  // Next-state and next micro-op: flush first, then hold on back-pressure.
  always_comb begin
    state_n  = state;
    rem_n    = rem_p0;
    vld_n    = vld_p0;
    exe6_n   = exe6_p0;
    reg_n    = reg_p0;
    addr_n   = addr_p0;
    store_n  = store_p0;
    last_n   = last_p0;
    is_multi = (bus.in_instr[15:14] == 2'b11);
    // LA/SA (opcode bit 1 set) transfer every register.
    acc_mask = bus.in_instr[13] ? '1 : bus.in_instr[NREG-1:0];
    acc_rem  = drop_lowest(acc_mask);
    run_rem  = drop_lowest(rem_p0);

    if (bus.flush) begin
      state_n = IDLE;
      rem_n   = '0;
      vld_n   = 1'b0;
      last_n  = 1'b0;
    end else if (bus.out_ready) begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && !is_multi) begin
            vld_n   = 1'b1;
            exe6_n  = {bus.in_instr[15:12], bus.in_instr[1:0]};
            reg_n   = bus.in_instr[11:9];
            addr_n  = bus.in_base;
            store_n = 1'b0;
            last_n  = 1'b1;
          end else if (bus.in_valid && (acc_mask != '0)) begin
            vld_n   = 1'b1;
            exe6_n  = {bus.in_instr[15:12], 2'b00};
            reg_n   = lowest_idx(acc_mask);
            addr_n  = bus.in_base;
            store_n = bus.in_instr[12];
            rem_n   = acc_rem;
            last_n  = (acc_rem == '0);
            state_n = (acc_rem == '0) ? IDLE : RUN;
          end else begin
            // Idle cycle or zero-mask LM/SM: a bubble.
            vld_n   = 1'b0;
            last_n  = 1'b0;
          end
        end
        RUN: begin
          vld_n   = 1'b1;
          reg_n   = lowest_idx(rem_p0);
          addr_n  = addr_p0 + AW'(1);
          rem_n   = run_rem;
          last_n  = (run_rem == '0);
          state_n = (run_rem == '0) ? IDLE : RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and micro-op output registers; reset aborts any expansion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem_p0   <= '0;
      vld_p0   <= 1'b0;
      exe6_p0  <= '0;
      reg_p0   <= '0;
      addr_p0  <= '0;
      store_p0 <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      state    <= state_n;
      rem_p0   <= rem_n;
      vld_p0   <= vld_n;
      exe6_p0  <= exe6_n;
      reg_p0   <= reg_n;
      addr_p0  <= addr_n;
      store_p0 <= store_n;
      last_p0  <= last_n;
    end
  end

endmodule

// File: doc/lmsm_uop_sequencer.md
Name: lmsm_uop_sequencer

Overview:
- Sits between register-read and the execute-stage ALU.
- Passes ordinary instructions through as a single micro-op.
- Expands multi-register memory instructions (LM 1100, SM 1101, LA 1110, SA 1111) into one micro-op per transferred register. Each micro-op carries its register index and word address.
- The ALU selects its operation with {opcode, 2'b00}, forwards out_addr on its B input, and produces the memory address. Upstream stalls while an expansion is in progress.

Parameters:
NREG, 8, number of architectural registers; also the LM/SM mask width
AW, 16, address/data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash from branch resolution
in_valid  in  1  in_instr/in_base are valid
in_instr  in  16  instruction word; [15:12] opcode, [11:9] RA, [7:0] register mask, [1:0] condition
in_base  in  AW  RA value (base address for LM/SM/LA/SA)
in_ready  out  1  sequencer accepts this cycle
out_ready  in  1  execute stage not stalled
out_valid  out  1  micro-op valid
out_instr_exe_6bit  out  6  {opcode, cond} to ALU
out_reg  out  3  register index for this micro-op
out_addr  out  AW  base or computed word address
out_is_store  out  1  micro-op is SM/SA
out_last  out  1  final micro-op of the instruction

Behaviour:
- Clock, reset and flush:
  - One clock, clk. rst is asynchronous and active-high.
  - On reset: state=IDLE, remaining mask=0, all outputs 0.
  - in_ready is combinational: out_ready && state==IDLE && !flush. It therefore follows out_ready after reset.
- States:
  - IDLE: ready for a new instruction.
  - RUN: a multi-register instruction has micro-ops remaining.
- Accept and advance:
  - accept = in_valid && in_ready.
  - advance = out_ready.
  - When out_ready=0, every output and all internal state hold.
- Pass-through (opcode[3:2]!=2'b11):
  - Applies on accept.
  - Next edge: out_valid=1, out_instr_exe_6bit={in_instr[15:12],in_instr[1:0]}, out_reg=in_instr[11:9], out_addr=in_base, out_is_store=0, out_last=1.
  - Latency is 1 cycle; throughput is 1 per cycle.
- Multi-register instructions:
  - mask = in_instr[7:0] for LM/SM, 8'hFF for LA/SA. Bit i selects register Ri.
  - Micro-ops are issued in ascending register index order.
  - in_base is captured on accept; later changes on in_base are ignored.
  - On accept, the first micro-op is loaded the same edge: out_reg = lowest set bit, out_addr = base, out_instr_exe_6bit = {opcode,2'b00}, out_is_store = opcode[0].
  - If more bits remain, go to RUN.
  - In RUN, each advance edge clears the issued bit and emits the next micro-op. out_addr increments by 1, modulo 2^AW (wraps FFFF->0000).
  - out_last=1 on the final micro-op; state returns to IDLE on that same edge.
  - N set bits produce N consecutive micro-ops with no bubble. The next instruction can be accepted on the edge after the last micro-op is issued.
- Zero mask (LM/SM with mask 8'h00):
  - The instruction is consumed in one cycle.
  - It emits a bubble (out_valid=0) and the sequencer stays in IDLE.
- Bubbles: if advance and nothing is accepted in IDLE, out_valid goes to 0 on the next edge.
- flush:
  - Has priority over accept and advance, and acts regardless of out_ready.
  - On the next edge: state=IDLE, remaining mask cleared, out_valid=0, out_last=0.
  - in_ready is 0 during the flush cycle.
- Reset asserted mid-expansion aborts immediately; no further micro-ops are issued.

Test Plan:
- ADD pass-through: in_instr=16'h1291, in_base=16'h0040, out_ready=1 -> next cycle out_valid=1, out_instr_exe_6bit=6'b000101, out_reg=1, out_addr=0040, out_last=1; in_ready stays 1.
- LM expansion: in_instr=16'hC085 (mask 1000_0101), in_base=0100 -> three consecutive micro-ops (R0,0100), (R2,0101), (R7,0102); out_last only on the third; in_ready=0 for the two cycles in RUN; out_is_store=0.
- SA with address wrap: in_instr=16'hF000, in_base=FFFE -> 8 micro-ops R0..R7 at FFFE, FFFF, 0000..0005; out_is_store=1; out_instr_exe_6bit=6'b111100.
- Back-pressure: during LM mask 8'h0F, drop out_ready for 3 cycles after the second micro-op -> outputs frozen at (R1, base+1); resume issues R2, R3 with no skipped or duplicated micro-ops.
- Flush mid-SM: in_instr=16'hD0FF, assert flush after 2 micro-ops -> next cycle out_valid=0, state IDLE; a following ADD is accepted the cycle after.
- Zero mask and reset: LM mask 8'h00 -> no micro-op, in_ready=1 the next cycle. Separately, assert rst asynchronously mid-LA -> out_valid=0 immediately, no micro-op after rst deasserts.
